// File: rtl/mem_responder.sv
// Memory-side responder: DEPTH x DATA_W RAM behind a cmd/addr handshake with WAIT_STATES busy cycles.
// Optional MMIO (SW in, LEDR out at 9'h100) enabled by defining MEM_RESP_MMIO_EN.
module mem_responder #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 1,
  parameter              INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              mem_ready,
  output logic              mem_err,
  input  logic [7:0]        SW,
  output logic [7:0]        LEDR
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {CMD_NONE = 2'b00, CMD_READ = 2'b01,
                            CMD_WRITE = 2'b10, CMD_ILL = 2'b11} cmd_t;

  localparam int unsigned       RAM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   LP_DEPTH    = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]        LP_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [DATA_W-1:0] r_ram [DEPTH];

  state_t            r_state;
  logic [3:0]        r_cnt;
  cmd_t              r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_read_data;
  logic              r_ready;
  logic              r_err;
  logic [7:0]        r_ledr;

  cmd_t              w_acc_cmd;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_fire;
  logic              w_in_range;
  logic              w_mmio;
  logic              w_err;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [DATA_W-1:0] w_rd_val;

  // With zero wait states the access completes on the sampling edge itself,
  // so the operands come straight from the inputs instead of the latches.
  always_comb begin
    w_acc_cmd  = r_cmd;
    w_acc_addr = r_addr;
    w_acc_data = r_data;
    if (r_state == S_IDLE) begin
      w_acc_cmd  = cmd_t'(mem_cmd);
      w_acc_addr = mem_addr;
      w_acc_data = write_data;
    end
  end

  assign w_fire = reset &&
                  (((r_state == S_IDLE) && (cmd_t'(mem_cmd) != CMD_NONE) && (WAIT_STATES == 0)) ||
                   ((r_state == S_BUSY) && (r_cnt == 4'd0)));

  assign w_in_range = ({1'b0, w_acc_addr} < LP_DEPTH);
  assign w_ram_idx  = w_acc_addr[RAM_AW-1:0];

`ifdef MEM_RESP_MMIO_EN
  localparam logic [ADDR_W-1:0] LP_MMIO_ADDR = ADDR_W'(9'h100);
  assign w_mmio = (w_acc_addr == LP_MMIO_ADDR);
`else
  logic w_unused_sw;
  assign w_unused_sw = ^SW;
  assign w_mmio      = 1'b0;
`endif

  assign w_err = (w_acc_cmd == CMD_ILL) || (!w_mmio && !w_in_range);

  always_comb begin
    w_rd_val = '0;
    if (w_mmio)
      w_rd_val = DATA_W'(SW);
    else if (w_in_range)
      w_rd_val = r_ram[w_ram_idx];
  end

  always_ff @(posedge clk) begin
    if (w_fire && (w_acc_cmd == CMD_WRITE) && w_in_range && !w_mmio)
      r_ram[w_ram_idx] <= w_acc_data;
  end

  // Illegal commands take the same BUSY path so every response has WAIT_STATES+1 latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_cmd       <= CMD_NONE;
      r_addr      <= '0;
      r_data      <= '0;
      r_read_data <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_ledr      <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_t'(mem_cmd) != CMD_NONE) begin
            r_cmd  <= cmd_t'(mem_cmd);
            r_addr <= mem_addr;
            r_data <= write_data;
            if (WAIT_STATES == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_BUSY;
              r_cnt   <= LP_CNT_INIT;
            end
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0)
            r_state <= S_RESP;
          else
            r_cnt <= r_cnt - 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_fire) begin
        r_ready <= 1'b1;
        r_err   <= w_err;
        if (w_acc_cmd == CMD_READ)
          r_read_data <= w_rd_val;
`ifdef MEM_RESP_MMIO_EN
        if ((w_acc_cmd == CMD_WRITE) && w_mmio)
          r_ledr <= w_acc_data[7:0];
`endif
      end
    end
  end

  assign read_data = r_read_data;
  assign mem_ready = r_ready;
  assign mem_err   = r_err;
  assign LEDR      = r_ledr;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (WAIT_STATES 0, 1, 3) driven in lockstep
// against a per-instance array model of RAM, read_data and LEDR.
module tb_mem_responder;
  localparam int NDUT = 3;
`ifdef MEM_RESP_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic [1:0]                mem_cmd;
  logic [8:0]                mem_addr;
  logic [15:0]               write_data;
  logic [7:0]                SW;
  logic [NDUT-1:0][15:0]     rd;
  logic [NDUT-1:0]           rdy;
  logic [NDUT-1:0]           err;
  logic [NDUT-1:0][7:0]      led;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_ram [NDUT][256];
  logic [15:0] m_rd  [NDUT];
  logic [7:0]  m_led [NDUT];

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(rd[0]), .mem_ready(rdy[0]), .mem_err(err[0]), .SW(SW), .LEDR(led[0]));
  mem_responder #(.DATA_W(16), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(rd[1]), .mem_ready(rdy[1]), .mem_err(err[1]), .SW(SW), .LEDR(led[1]));
  mem_responder #(.DATA_W(16), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .mem_cmd(mem_cmd), .mem_addr(mem_addr), .write_data(write_data),
    .read_data(rd[2]), .mem_ready(rdy[2]), .mem_err(err[2]), .SW(SW), .LEDR(led[2]));

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  // One request, then six observation cycles; ready is expected on cycle WAIT_STATES+1.
  task automatic run_txn(input logic [1:0] cmd, input logic [8:0] addr,
                         input logic [15:0] data, input string tag);
    bit          mmio, inr, exp_err;
    int          first [NDUT];
    int          nrdy  [NDUT];
    int          nerr  [NDUT];
    logic [15:0] rd_at [NDUT];
    logic        err_at[NDUT];
    mmio    = MMIO && (addr == 9'h100);
    inr     = (addr < 9'd256);
    exp_err = (cmd == 2'b11) || (!mmio && !inr);
    for (int i = 0; i < NDUT; i++) begin
      if (cmd == 2'b01)
        m_rd[i] = mmio ? {8'h00, SW} : (inr ? m_ram[i][addr[7:0]] : 16'h0000);
      else if (cmd == 2'b10) begin
        if (mmio)     m_led[i] = data[7:0];
        else if (inr) m_ram[i][addr[7:0]] = data;
      end
      first[i] = 0; nrdy[i] = 0; nerr[i] = 0; rd_at[i] = 'x; err_at[i] = 1'bx;
    end
    @(negedge clk);
    mem_cmd = cmd; mem_addr = addr; write_data = data;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
        if (rdy[i]) begin
          nrdy[i]++;
          if (first[i] == 0) first[i] = k;
          rd_at[i] = rd[i]; err_at[i] = err[i];
        end
        if (err[i]) nerr[i]++;
      end
      if (k == 1) begin
        mem_cmd = 2'b00; mem_addr = 9'($urandom); write_data = 16'($urandom);
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      total++;
      if (first[i] !== ws_of(i) + 1) begin bad++;
        $display("FAIL %s dut%0d latency got=%0d want=%0d", tag, i, first[i], ws_of(i) + 1); end
      total++;
      if (nrdy[i] !== 1) begin bad++;
        $display("FAIL %s dut%0d ready_cycles got=%0d want=1", tag, i, nrdy[i]); end
      total++;
      if (nerr[i] !== (exp_err ? 1 : 0)) begin bad++;
        $display("FAIL %s dut%0d err_cycles got=%0d want=%0d", tag, i, nerr[i], exp_err ? 1 : 0); end
      total++;
      if (err_at[i] !== exp_err) begin bad++;
        $display("FAIL %s dut%0d err_with_ready got=%b want=%b", tag, i, err_at[i], exp_err); end
      total++;
      if (rd_at[i] !== m_rd[i]) begin bad++;
        $display("FAIL %s dut%0d read_data got=%h want=%h", tag, i, rd_at[i], m_rd[i]); end
      total++;
      if (rd[i] !== m_rd[i]) begin bad++;
        $display("FAIL %s dut%0d read_hold got=%h want=%h", tag, i, rd[i], m_rd[i]); end
      total++;
      if (led[i] !== m_led[i]) begin bad++;
        $display("FAIL %s dut%0d ledr got=%h want=%h", tag, i, led[i], m_led[i]); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_cmd = 2'b00; mem_addr = '0; write_data = '0; SW = 8'h00;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      m_rd[i] = 16'h0000; m_led[i] = 8'h00;
      total++;
      if ({rd[i], rdy[i], err[i], led[i]} !== 26'd0) begin bad++;
        $display("FAIL reset dut%0d outs got=%h/%b/%b/%h want=0", i, rd[i], rdy[i], err[i], led[i]); end
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int a = 0; a < 256; a++) run_txn(2'b10, 9'(a), 16'($urandom), "fill");
  endtask

  task automatic test_basic();
    run_txn(2'b10, 9'h005, 16'hBEEF, "write_beef");
    run_txn(2'b01, 9'h005, 16'h0000, "read_beef");
    total++;
    if (rd[1] !== 16'hBEEF) begin bad++;
      $display("FAIL read_beef_const got=%h want=beef", rd[1]); end
  endtask

  task automatic test_out_of_range();
    run_txn(2'b01, 9'h1FF, 16'h0000, "read_oor");
    run_txn(2'b10, 9'h1FF, 16'h1234, "write_oor");
    for (int a = 0; a < 256; a++) run_txn(2'b01, 9'(a), 16'h0000, "scan_after_oor");
  endtask

  task automatic test_illegal();
    run_txn(2'b01, 9'h020, 16'h0000, "pre_illegal_read");
    run_txn(2'b11, 9'h020, 16'h5555, "illegal_a");
    run_txn(2'b11, 9'h1FF, 16'h6666, "illegal_b");
    run_txn(2'b01, 9'h020, 16'h0000, "post_illegal_read");
  endtask

  task automatic test_mmio();
    SW = 8'h5A;
    run_txn(2'b01, 9'h100, 16'h0000, "mmio_read");
    run_txn(2'b10, 9'h100, 16'hFF3C, "mmio_write");
    SW = 8'hC3;
    run_txn(2'b01, 9'h100, 16'h0000, "mmio_read2");
  endtask

  task automatic test_reset_abort();
    run_txn(2'b10, 9'h010, 16'h1357, "pre_abort_write");
    @(negedge clk);
    mem_cmd = 2'b10; mem_addr = 9'h010; write_data = 16'hAAAA;
    @(negedge clk);
    mem_cmd = 2'b00;
    reset = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      total++;
      if ({rd[i], rdy[i], err[i], led[i]} !== 26'd0) begin bad++;
        $display("FAIL abort_outs dut%0d got=%h/%b/%b/%h want=0", i, rd[i], rdy[i], err[i], led[i]); end
      m_rd[i] = 16'h0000; m_led[i] = 8'h00;
    end
    // the zero-wait instance had already passed its commit edge
    m_ram[0][8'h10] = 16'hAAAA;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_txn(2'b01, 9'h010, 16'h0000, "read_after_abort");
  endtask

  task automatic test_random();
    logic [1:0] c;
    logic [8:0] a;
    for (int n = 0; n < 300; n++) begin
      c = 2'($urandom_range(1, 3));
      a = ($urandom_range(0, 9) < 8) ? 9'($urandom_range(0, 255)) : 9'($urandom);
      SW = 8'($urandom);
      run_txn(c, a, 16'($urandom), "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_basic();
    test_out_of_range();
    test_illegal();
    test_mmio();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
